// File: rtl/sha3_padder.sv
// SHA3-256 message padder: packs 64-bit words into 136-byte rate blocks,
// appends the 0x06/0x80 padding and paces blocks into the Keccak core.
module sha3_padder #(
    parameter int RATE_BYTES = 136,
    parameter int WORD_BYTES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WORD_BYTES*8-1:0]   msg_data,
    input  logic                      msg_valid,
    input  logic                      msg_last,
    input  logic [3:0]                msg_bytes,
    output logic                      msg_ready,
    output logic [RATE_BYTES*8-1:0]   blk_data,
    output logic                      blk_valid,
    output logic                      blk_more,
    input  logic                      core_hash_next,
    input  logic                      core_out_valid
);

    localparam int          NWORDS    = RATE_BYTES / WORD_BYTES;
    localparam logic [4:0]  LAST_WIDX = 5'(NWORDS - 1);
    localparam logic [7:0]  P_FULL    = 8'(RATE_BYTES);
    localparam logic [7:0]  P_LASTB   = 8'(RATE_BYTES - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [RATE_BYTES-1:0][7:0]   r_buf;
    logic [4:0]                   r_widx;
    logic                         r_more_q;
    logic                         r_pad_pending;
    logic                         r_core_free;
    logic                         r_blk_more;

    logic                         w_accept;
    logic                         w_issue;
    logic [3:0]                   w_nb;
    logic [7:0]                   w_p;

    // Out-of-range byte counts saturate to a full word so the stream never stalls.
    assign w_nb = (!msg_last || msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
    assign w_p  = {r_widx, 3'b000} + {4'b0000, w_nb};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        msg_ready = 1'b0;
        blk_valid = 1'b0;
        w_accept  = 1'b0;
        w_issue   = 1'b0;
        unique case (r_state)
            S_FILL: begin
                msg_ready = 1'b1;
                w_accept  = msg_valid;
                if (msg_valid && (msg_last || r_widx == LAST_WIDX)) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // core_free only holds before the first block of a message.
                w_issue   = r_core_free || core_hash_next;
                blk_valid = w_issue;
                if (w_issue && !(r_more_q && r_pad_pending)) begin
                    w_next = r_more_q ? S_FILL : S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_out_valid) begin
                    w_next = S_FILL;
                end
            end
            default: w_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf         <= '0;
            r_widx        <= '0;
            r_more_q      <= 1'b0;
            r_pad_pending <= 1'b0;
            r_core_free   <= 1'b1;
            r_blk_more    <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (4'(i) < w_nb) begin
                        r_buf[{r_widx, 3'(i)}] <= msg_data[8*i +: 8];
                    end
                end
                if (msg_last) begin
                    if (w_p == P_FULL) begin
                        r_more_q      <= 1'b1;
                        r_pad_pending <= 1'b1;
                    end else begin
                        r_buf[w_p] <= (w_p == P_LASTB) ? 8'h86 : 8'h06;
                        if (w_p != P_LASTB) begin
                            r_buf[RATE_BYTES-1] <= 8'h80;
                        end
                        r_more_q <= 1'b0;
                    end
                end else if (r_widx == LAST_WIDX) begin
                    r_more_q <= 1'b1;
                end else begin
                    r_widx <= r_widx + 5'd1;
                end
            end
            if (w_issue) begin
                r_blk_more  <= r_more_q;
                r_core_free <= 1'b0;
                r_widx      <= '0;
                r_buf       <= '0;
                // Message ended exactly on a block boundary: queue a pad-only block.
                if (r_more_q && r_pad_pending) begin
                    r_buf[0]            <= 8'h06;
                    r_buf[RATE_BYTES-1] <= 8'h80;
                    r_more_q            <= 1'b0;
                    r_pad_pending       <= 1'b0;
                end
            end
            if (r_state == S_WAIT && core_out_valid) begin
                r_core_free <= 1'b1;
            end
        end
    end

    assign blk_more = r_blk_more;

    always_comb begin
        blk_data = '0;
        for (int k = 0; k < RATE_BYTES; k++) begin
            for (int b = 0; b < 8; b++) begin
                blk_data[RATE_BYTES*8-1-8*k-b] = r_buf[k][b];
            end
        end
    end

endmodule

// File: tb/tb_sha3_padder.sv
// Directed bench for sha3_padder: block contents, padding boundaries,
// core pacing via hash_next/out_valid, stalls and mid-message reset.
module tb_sha3_padder;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   msg_data;
    logic          msg_valid;
    logic          msg_last;
    logic [3:0]    msg_bytes;
    logic          msg_ready;
    logic [1087:0] blk_data;
    logic          blk_valid;
    logic          blk_more;
    logic          core_hash_next;
    logic          core_out_valid;

    int errors = 0;
    int checks = 0;

    sha3_padder dut (
        .clk            (clk),
        .rst            (rst),
        .msg_data       (msg_data),
        .msg_valid      (msg_valid),
        .msg_last       (msg_last),
        .msg_bytes      (msg_bytes),
        .msg_ready      (msg_ready),
        .blk_data       (blk_data),
        .blk_valid      (blk_valid),
        .blk_more       (blk_more),
        .core_hash_next (core_hash_next),
        .core_out_valid (core_out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Bit-palindromic bytes read the same after the per-byte bit reversal.
    logic [7:0] pal [16] = '{8'h18, 8'h24, 8'h3C, 8'h42, 8'h5A, 8'h66,
                             8'h7E, 8'h81, 8'h99, 8'hA5, 8'hBD, 8'hC3,
                             8'hDB, 8'hE7, 8'hFF, 8'h00};

    logic [1087:0] cap [3];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sl(input logic [1087:0] v, input int w);
        return v[1087-64*w -: 64];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic l,
                        input logic [3:0] b);
        msg_data  = d;
        msg_last  = l;
        msg_bytes = b;
        msg_valid = 1'b1;
        #1;
        for (int i = 0; i < 50 && !msg_ready; i++) begin
            step();
        end
        chk("send_ready", 64'(msg_ready), 64'd1);
        step();
        msg_valid = 1'b0;
        #1;
    endtask

    task automatic finish_msg(input string tag);
        core_out_valid = 1'b1;
        step();
        core_out_valid = 1'b0;
        #1;
        chk(tag, 64'(msg_ready), 64'd1);
    endtask

    initial begin
        int n, nblk, tmr, pulses;
        logic busy, hn, ov, fin, acc;

        rst            = 1'b1;
        msg_data       = '0;
        msg_valid      = 1'b0;
        msg_last       = 1'b0;
        msg_bytes      = 4'd0;
        core_hash_next = 1'b0;
        core_out_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(msg_ready), 64'd1);
        chk("rst_valid", 64'(blk_valid), 64'd0);
        chk("rst_more",  64'(blk_more),  64'd0);
        rst = 1'b0;
        step();

        // Empty message
        send(64'h0, 1'b1, 4'd0);
        chk("empty_valid", 64'(blk_valid), 64'd1);
        chk("empty_ready", 64'(msg_ready), 64'd0);
        chk("empty_top", sl(blk_data, 0), 64'h6000_0000_0000_0000);
        chk("empty_mid", 64'(|blk_data[1023:64]), 64'd0);
        chk("empty_bot", sl(blk_data, 16), 64'h0000_0000_0000_0001);
        step();
        chk("empty_pulse", 64'(blk_valid), 64'd0);
        chk("empty_more", 64'(blk_more), 64'd0);
        core_hash_next = 1'b1;
        #1;
        chk("hn_ignored_wait", 64'(blk_valid), 64'd0);
        step();
        core_hash_next = 1'b0;
        chk("wait_stalls", 64'(msg_ready), 64'd0);
        finish_msg("empty_done");

        // "abc"
        send(64'h0000_0000_0063_6261, 1'b1, 4'd3);
        chk("abc_valid", 64'(blk_valid), 64'd1);
        chk("abc_top", sl(blk_data, 0), 64'h8646_C660_0000_0000);
        chk("abc_bot", sl(blk_data, 16), 64'h1);
        step();
        chk("abc_more", 64'(blk_more), 64'd0);
        finish_msg("abc_done");

        // Saturation: short non-last word and oversize last count act as 8
        send({8{8'hA5}}, 1'b0, 4'd3);
        send({8{8'h5A}}, 1'b1, 4'd15);
        chk("sat_valid", 64'(blk_valid), 64'd1);
        chk("sat_w0", sl(blk_data, 0), {8{8'hA5}});
        chk("sat_w1", sl(blk_data, 1), {8{8'h5A}});
        chk("sat_w2", sl(blk_data, 2), 64'h6000_0000_0000_0000);
        chk("sat_bot", sl(blk_data, 16), 64'h1);
        step();
        finish_msg("sat_done");

        // 135 zero bytes: pad collapses to 0x86 in the last byte
        for (int i = 0; i < 16; i++) send(64'h0, 1'b0, 4'd8);
        send(64'h0, 1'b1, 4'd7);
        chk("m135_valid", 64'(blk_valid), 64'd1);
        chk("m135_bot", sl(blk_data, 16), 64'h61);
        chk("m135_rest", 64'(|blk_data[1087:64]), 64'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (blk_valid) pulses++;
        end
        chk("m135_one_pulse", 64'(pulses), 64'd0);
        chk("m135_more", 64'(blk_more), 64'd0);
        finish_msg("m135_done");

        // 136 bytes: data block then pad-only block gated by hash_next
        for (int i = 0; i < 16; i++) send({8{8'hFF}}, 1'b0, 4'd8);
        send({8{8'hFF}}, 1'b1, 4'd8);
        chk("m136_b1_valid", 64'(blk_valid), 64'd1);
        chk("m136_b1_ones", 64'(&blk_data), 64'd1);
        step();
        chk("m136_b1_more", 64'(blk_more), 64'd1);
        chk("m136_ready", 64'(msg_ready), 64'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (blk_valid) pulses++;
            step();
        end
        chk("m136_gated", 64'(pulses), 64'd0);
        core_hash_next = 1'b1;
        #1;
        chk("m136_b2_valid", 64'(blk_valid), 64'd1);
        chk("m136_b2_top", sl(blk_data, 0), 64'h6000_0000_0000_0000);
        chk("m136_b2_mid", 64'(|blk_data[1023:64]), 64'd0);
        chk("m136_b2_bot", sl(blk_data, 16), 64'h1);
        step();
        core_hash_next = 1'b0;
        chk("m136_b2_more", 64'(blk_more), 64'd0);
        chk("m136_b2_pulse", 64'(blk_valid), 64'd0);
        finish_msg("m136_done");

        // 300 bytes, msg_valid held high, simple core timing model
        n = 0; nblk = 0; tmr = 0; busy = 0; hn = 0; ov = 0; fin = 0;
        for (int cyc = 0; cyc < 800 && !fin; cyc++) begin
            msg_valid      = (n < 38);
            msg_data       = {8{pal[n % 16]}};
            msg_last       = (n == 37);
            msg_bytes      = (n == 37) ? 4'd4 : 4'd8;
            core_hash_next = hn;
            core_out_valid = ov;
            #1;
            if (ov) fin = 1'b1;
            if (blk_valid) begin
                if (nblk < 3) cap[nblk] = blk_data;
                chk("m300_ready_at_issue", 64'(msg_ready), 64'd0);
                nblk++;
                hn   = 1'b0;
                busy = 1'b1;
                tmr  = 20;
            end
            acc = msg_valid && msg_ready;
            step();
            if (acc) n++;
            ov = 1'b0;
            if (busy) begin
                if (tmr > 0) tmr--;
                else begin
                    busy = 1'b0;
                    if (blk_more) hn = 1'b1;
                    else ov = 1'b1;
                end
            end
        end
        msg_valid      = 1'b0;
        core_hash_next = 1'b0;
        core_out_valid = 1'b0;
        #1;
        chk("m300_done", 64'(fin), 64'd1);
        chk("m300_blocks", 64'(nblk), 64'd3);
        chk("m300_words", 64'(n), 64'd38);
        chk("m300_ready_end", 64'(msg_ready), 64'd1);
        for (int w = 0; w < 17; w++) begin
            chk("m300_b1", sl(cap[0], w), {8{pal[w % 16]}});
            chk("m300_b2", sl(cap[1], w), {8{pal[(17 + w) % 16]}});
        end
        for (int w = 0; w < 3; w++) begin
            chk("m300_b3", sl(cap[2], w), {8{pal[(34 + w) % 16]}});
        end
        chk("m300_b3_tail", sl(cap[2], 3), {{4{pal[5]}}, 8'h60, 24'h0});
        chk("m300_b3_zero", 64'(|cap[2][1087-256:64]), 64'd0);
        chk("m300_b3_bot", sl(cap[2], 16), 64'h1);

        // Reset in the middle of a fill, then "abc"
        step();
        for (int i = 0; i < 5; i++) send({8{8'h3C}}, 1'b0, 4'd8);
        rst = 1'b1;
        #1;
        chk("mrst_ready", 64'(msg_ready), 64'd1);
        chk("mrst_valid", 64'(blk_valid), 64'd0);
        chk("mrst_more",  64'(blk_more),  64'd0);
        step();
        rst = 1'b0;
        step();
        send(64'h0000_0000_0063_6261, 1'b1, 4'd3);
        chk("mrst_abc_valid", 64'(blk_valid), 64'd1);
        chk("mrst_abc_top", sl(blk_data, 0), 64'h8646_C660_0000_0000);
        chk("mrst_abc_mid", 64'(|blk_data[1023:64]), 64'd0);
        chk("mrst_abc_bot", sl(blk_data, 16), 64'h1);
        step();
        chk("mrst_abc_more", 64'(blk_more), 64'd0);
        finish_msg("mrst_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
